// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared types and index helpers for the fifo round-robin arbiter.
// Imported by the interface, the picker and the top.
package fifo_rr_arbiter_pkg;

    typedef enum logic {IDLE, HOLD} arb_state_e;

    // Index width for a requester count; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned num);
        return (num > 1) ? $clog2(num) : 1;
    endfunction

    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned num);
        return (idx + 1 >= num) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fifo_rr_arbiter_if.sv
// Requester-side and fifo-side handshake bundle of the round-robin arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface fifo_rr_arbiter_if
    import fifo_rr_arbiter_pkg::*;
#(
    parameter int unsigned num_p   = 4,
    parameter int unsigned width_p = 8
) ();

    localparam int unsigned id_w = id_width(num_p);

    logic [num_p-1:0]         valid_i;
    logic [num_p*width_p-1:0] data_i;
    logic [num_p-1:0]         ready_o;
    logic                     valid_o;
    logic [width_p-1:0]       data_o;
    logic [id_w-1:0]          id_o;
    logic                     ready_i;

    modport slave (
        input  valid_i,
        input  data_i,
        input  ready_i,
        output ready_o,
        output valid_o,
        output data_o,
        output id_o
    );

    modport master (
        output valid_i,
        output data_i,
        output ready_i,
        input  ready_o,
        input  valid_o,
        input  data_o,
        input  id_o
    );

endinterface

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// Combinational rotating first-one finder: returns the first set request
// at or after start_i, wrapping modulo num_p (num_p need not be a power of two).
module rr_pick #(
    parameter int unsigned num_p = 4,
    parameter int unsigned id_w  = 2
) (
    input  logic [num_p-1:0] req_i,
    input  logic [id_w-1:0]  start_i,
    output logic             found_o,
    output logic [id_w-1:0]  idx_o
);

    function automatic int unsigned wrap(input int unsigned a);
        return (a >= num_p) ? a - num_p : a;
    endfunction

    int unsigned base;

    always_comb begin
        base    = (32'(start_i) < num_p) ? 32'(start_i) : 0;
        found_o = 1'b0;
        idx_o   = '0;
        // Scan from the far end so the closest candidate to start_i wins last.
        for (int i = int'(num_p) - 1; i >= 0; i--) begin
            if (req_i[wrap(base + 32'(i))]) begin
                found_o = 1'b1;
                idx_o   = id_w'(wrap(base + 32'(i)));
            end
        end
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter sharing one fifo write port among num_p producers, with
// burst locking; define FIFO_RR_ARBITER_PERF_EN to add per-requester beat counters.
module fifo_rr_arbiter
    import fifo_rr_arbiter_pkg::*;
#(
    parameter int unsigned num_p   = 4,
    parameter int unsigned width_p = 8,
    parameter int unsigned burst_p = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    fifo_rr_arbiter_if.slave     bus
`ifdef FIFO_RR_ARBITER_PERF_EN
    ,
    output logic [num_p*16-1:0]  beats_o
`endif
);

    localparam int unsigned id_w      = id_width(num_p);
    localparam int unsigned beat_w    = $clog2(burst_p + 1);
    localparam logic [beat_w-1:0] beat_last = beat_w'(burst_p - 1);

    arb_state_e        state_q, state_d;
    logic [id_w-1:0]   ptr_q, ptr_d;
    logic [id_w-1:0]   gnt_q, gnt_d;
    logic [beat_w-1:0] beat_q, beat_d;

    logic [id_w-1:0]   start;
    logic [id_w-1:0]   pick_idx;
    logic              pick_found;
    logic              hold_live;
    logic              act_valid;
    logic [id_w-1:0]   sel;
    logic [width_p-1:0] sel_data;
    logic              xfer;

    // A locked grant survives only while its owner keeps valid high.
    assign hold_live = (state_q == HOLD) && bus.valid_i[gnt_q];
    assign start     = (state_q == HOLD) ? id_w'(next_idx(32'(gnt_q), num_p)) : ptr_q;

    rr_pick #(
        .num_p (num_p),
        .id_w  (id_w)
    ) u_pick (
        .req_i   (bus.valid_i),
        .start_i (start),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign sel       = hold_live ? gnt_q : pick_idx;
    assign act_valid = hold_live | pick_found;
    assign xfer      = act_valid & bus.ready_i & ~reset_i;

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < int'(num_p); k++) begin
            if (sel == id_w'(k)) begin
                sel_data = bus.data_i[k*width_p +: width_p];
            end
        end
    end

    always_comb begin
        bus.valid_o = 1'b0;
        bus.id_o    = '0;
        bus.data_o  = '0;
        bus.ready_o = '0;
        if (!reset_i) begin
            bus.valid_o = act_valid;
            bus.id_o    = sel;
            bus.data_o  = sel_data;
            for (int k = 0; k < int'(num_p); k++) begin
                if (act_valid && sel == id_w'(k)) begin
                    bus.ready_o[k] = bus.ready_i;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        beat_d  = beat_q;
        if (hold_live) begin
            if (xfer) begin
                if (beat_q == beat_last) begin
                    state_d = IDLE;
                    ptr_d   = start;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
        end else begin
            // IDLE, or HOLD whose owner dropped valid: arbitrate afresh this cycle.
            ptr_d = start;
            if (!pick_found) begin
                state_d = IDLE;
            end else if (xfer && burst_p == 1) begin
                state_d = IDLE;
                ptr_d   = id_w'(next_idx(32'(pick_idx), num_p));
            end else begin
                state_d = HOLD;
                gnt_d   = pick_idx;
                beat_d  = xfer ? beat_w'(1) : '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            beat_q  <= beat_d;
        end
    end

`ifdef FIFO_RR_ARBITER_PERF_EN
    logic [15:0] cnt_q [num_p];

    for (genvar k = 0; k < int'(num_p); k++) begin : g_perf
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                cnt_q[k] <= '0;
            end else if (bus.valid_i[k] && bus.ready_o[k] && cnt_q[k] != 16'hFFFF) begin
                cnt_q[k] <= cnt_q[k] + 16'd1;
            end
        end
        assign beats_o[k*16 +: 16] = cnt_q[k];
    end
`endif

`ifndef SYNTHESIS
    a_ready_onehot0 : assert property (@(posedge clk_i) disable iff (reset_i)
        $onehot0(bus.ready_o));
    a_ready_needs_valid : assert property (@(posedge clk_i) disable iff (reset_i)
        (|bus.ready_o) |-> bus.valid_o);
`endif

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Scoreboard bench for fifo_rr_arbiter: stimulus queues expected {id,data} beats,
// a negedge monitor pops and compares on every downstream transfer.
module tb_fifo_rr_arbiter;

    localparam int unsigned NumP   = 4;
    localparam int unsigned WidthP = 8;

    logic clk = 1'b0;
    logic rst;
    logic fifo_mode;
    logic yumi;
    logic ready_drv;

    int total = 0;
    int bad   = 0;

    logic [9:0] exp_q [$];
    logic [9:0] exp_beat;

    fifo_rr_arbiter_if #(.num_p(NumP), .width_p(WidthP)) bus ();

`ifdef FIFO_RR_ARBITER_PERF_EN
    logic [NumP*16-1:0] beats;
`endif

    fifo_rr_arbiter #(
        .num_p   (NumP),
        .width_p (WidthP),
        .burst_p (2)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
`ifdef FIFO_RR_ARBITER_PERF_EN
        ,
        .beats_o (beats)
`endif
    );

    always #5 clk = ~clk;

    // Depth-4 downstream fifo model, used only when fifo_mode is set.
    logic [7:0] fmem [4];
    logic [1:0] wr_q, rd_q;
    logic [2:0] cnt_q;
    logic       f_push, f_pop;

    assign bus.ready_i = fifo_mode ? (cnt_q < 3'd4) : ready_drv;
    assign f_push      = fifo_mode && !rst && bus.valid_o && bus.ready_i;
    assign f_pop       = yumi && (cnt_q != 3'd0);

    always @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (f_push) begin
                fmem[wr_q] <= bus.data_o;
                wr_q       <= wr_q + 2'd1;
            end
            if (f_pop) rd_q <= rd_q + 2'd1;
            cnt_q <= cnt_q + {2'b0, f_push} - {2'b0, f_pop};
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic push_exp(input logic [1:0] id, input logic [7:0] data);
        exp_q.push_back({id, data});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [7:0] d2);
        bus.data_i = {8'h13, d2, 8'h11, 8'h10};
    endtask

    // Monitor: every downstream transfer must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && bus.valid_o && bus.ready_i) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL beat: unexpected id=%0d data=%h, none expected", bus.id_o,
                         bus.data_o);
            end else begin
                exp_beat = exp_q.pop_front();
                chk("beat", 32'({bus.id_o, bus.data_o}), 32'(exp_beat));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        fifo_mode   = 1'b0;
        yumi        = 1'b0;
        ready_drv   = 1'b1;
        bus.valid_i = 4'b1111;
        set_data(8'h12);

        // Reset holds everything quiet even with all requesters valid.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rst_valid", 32'(bus.valid_o), 32'd0);
            chk("rst_ready", 32'(bus.ready_o), 32'd0);
        end
        step();
        rst = 1'b0;

        // All valid, ready high: pairs of beats rotating 0,1,2,3,0.
        push_exp(2'd0, 8'h10); push_exp(2'd0, 8'h10);
        push_exp(2'd1, 8'h11); push_exp(2'd1, 8'h11);
        push_exp(2'd2, 8'h12); push_exp(2'd2, 8'h12);
        push_exp(2'd3, 8'h13); push_exp(2'd3, 8'h13);
        push_exp(2'd0, 8'h10); push_exp(2'd0, 8'h10);
        @(negedge clk);
        chk("first_id", 32'(bus.id_o), 32'd0);
        chk("first_data", 32'(bus.data_o), 32'h10);
        for (int i = 0; i < 10; i++) step();
        bus.valid_i = 4'b0000;
        @(negedge clk);
        chk("idle_valid", 32'(bus.valid_o), 32'd0);
        step();

        // Stall on req2; req0 joins mid-stall and must wait its turn.
        bus.valid_i = 4'b0100;
        set_data(8'hA5);
        ready_drv   = 1'b0;
        push_exp(2'd2, 8'hA5);
        push_exp(2'd0, 8'h10);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_id", 32'(bus.id_o), 32'd2);
            chk("stall_data", 32'(bus.data_o), 32'hA5);
            chk("stall_ready", 32'(bus.ready_o), 32'd0);
            chk("stall_valid", 32'(bus.valid_o), 32'd1);
            step();
            bus.valid_i = 4'b0101;
        end
        ready_drv = 1'b1;
        step();
        bus.valid_i = 4'b0001;
        step();
        bus.valid_i = 4'b0000;
        set_data(8'h12);
        step();

        // Early release: req1 drops after one beat, req3 follows with no bubble.
        bus.valid_i = 4'b1010;
        push_exp(2'd1, 8'h11);
        push_exp(2'd3, 8'h13);
        push_exp(2'd3, 8'h13);
        push_exp(2'd0, 8'h10);
        step();
        bus.valid_i = 4'b1000;
        @(negedge clk);
        chk("release_id", 32'(bus.id_o), 32'd3);
        chk("release_valid", 32'(bus.valid_o), 32'd1);
        step();
        bus.valid_i = 4'b1001;
        step();
        step();
        bus.valid_i = 4'b0000;
        step();

        // Shared depth-4 fifo: fills with four beats, then backpressure locks req2.
        rst = 1'b1;
        step();
        step();
        rst         = 1'b0;
        fifo_mode   = 1'b1;
        bus.valid_i = 4'b1111;
        push_exp(2'd0, 8'h10); push_exp(2'd0, 8'h10);
        push_exp(2'd1, 8'h11); push_exp(2'd1, 8'h11);
        for (int i = 0; i < 4; i++) step();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("full_ready", 32'(bus.ready_o), 32'd0);
            chk("full_id", 32'(bus.id_o), 32'd2);
            chk("full_count", 32'(cnt_q), 32'd4);
            step();
        end
        bus.valid_i = 4'b0000;
        step();
        yumi = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("drain_data", 32'(fmem[rd_q]), (i < 2) ? 32'h10 : 32'h11);
            step();
        end
        yumi = 1'b0;
        @(negedge clk);
        chk("drain_empty", 32'(cnt_q), 32'd0);
        step();
        fifo_mode = 1'b0;

        // Reset in the middle of a req1 burst clears pointer and lock.
        bus.valid_i = 4'b0010;
        push_exp(2'd1, 8'h11);
        step();
        bus.valid_i = 4'b1111;
        rst         = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 32'(bus.valid_o), 32'd0);
        step();
        step();
        rst = 1'b0;
        push_exp(2'd0, 8'h10);
        @(negedge clk);
        chk("postrst_id", 32'(bus.id_o), 32'd0);
`ifdef FIFO_RR_ARBITER_PERF_EN
        chk("postrst_beats", 32'(beats == '0), 32'd1);
`endif
        step();
        bus.valid_i = 4'b0000;
        step();
        step();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
